// File: rtl/led_mode_sequencer.sv
// Sequences four LED pattern-mode generators onto one 8-bit LED bus:
// gates generator enables, pulses restarts, rotates modes and registers the pattern.
module led_mode_sequencer #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned STEPS    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       auto,
  input  logic [1:0] mode_sel,
  input  logic       sel_load,
  input  logic [7:0] pat0,
  input  logic [7:0] pat1,
  input  logic [7:0] pat2,
  input  logic [7:0] pat3,
  output logic [3:0] mode_en,
  output logic [3:0] mode_clr,
  output logic [1:0] cur_mode,
  output logic [7:0] OUT
);

  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    SWITCH = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [DIV_W-1:0]  div, div_d;
  logic [STEP_W-1:0] step_cnt, step_cnt_d;
  logic [1:0]        next_mode, next_mode_d;
  logic [1:0]        cur_mode_d;
  logic [3:0]        mode_en_d, mode_clr_d;
  logic [7:0]        out_d;
  logic [7:0]        pat_cur;
  logic              tick;

  function automatic logic [3:0] onehot(input logic [1:0] m);
    logic [3:0] r;
    r    = 4'b0000;
    r[m] = 1'b1;
    return r;
  endfunction

  // Pattern of the generator currently driving the bus
  always_comb begin
    pat_cur = pat0;
    case (cur_mode)
      2'd0:    pat_cur = pat0;
      2'd1:    pat_cur = pat1;
      2'd2:    pat_cur = pat2;
      default: pat_cur = pat3;
    endcase
  end

  assign tick = (state == RUN) && en && (div == DIV_LAST);

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_d     = state;
    div_d       = div;
    step_cnt_d  = step_cnt;
    next_mode_d = next_mode;
    cur_mode_d  = cur_mode;
    out_d       = OUT;
    mode_en_d   = 4'b0000;
    mode_clr_d  = 4'b0000;

    case (state)
      IDLE: begin
        if (sel_load) begin
          cur_mode_d = mode_sel;
        end
        if (en) begin
          state_d    = START;
          mode_clr_d = onehot(cur_mode_d);
        end
      end

      START: begin
        state_d    = RUN;
        div_d      = '0;
        step_cnt_d = '0;
        mode_en_d  = en ? onehot(cur_mode) : 4'b0000;
      end

      RUN: begin
        if (en) begin
          div_d = tick ? '0 : div + 1'b1;
        end
        if (tick) begin
          out_d = pat_cur;
          if (step_cnt != STEP_LAST) begin
            step_cnt_d = step_cnt + 1'b1;
          end
        end
        // Manual request beats auto rotation; a same-mode request still restarts
        if (sel_load) begin
          state_d     = SWITCH;
          next_mode_d = mode_sel;
        end else if (auto && tick && (step_cnt == STEP_LAST)) begin
          state_d     = SWITCH;
          next_mode_d = cur_mode + 2'd1;
        end
        if (state_d == RUN && en) begin
          mode_en_d = onehot(cur_mode);
        end
      end

      SWITCH: begin
        state_d    = START;
        cur_mode_d = next_mode;
        mode_clr_d = onehot(next_mode);
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      div       <= '0;
      step_cnt  <= '0;
      next_mode <= 2'd0;
      cur_mode  <= 2'd0;
      OUT       <= 8'h00;
      mode_en   <= 4'b0000;
      mode_clr  <= 4'b0000;
    end else begin
      state     <= state_d;
      div       <= div_d;
      step_cnt  <= step_cnt_d;
      next_mode <= next_mode_d;
      cur_mode  <= cur_mode_d;
      OUT       <= out_d;
      mode_en   <= mode_en_d;
      mode_clr  <= mode_clr_d;
    end
  end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer: a rotation vector table plus
// hand-written sequences for freeze, manual select, async reset and divided ticks.
module tb_led_mode_sequencer;

  logic       clk;
  logic       reset, reset2;
  logic       en, en2;
  logic       auto;
  logic [1:0] mode_sel;
  logic       sel_load;
  logic [7:0] pat0, pat1, pat2, pat3;
  logic [3:0] mode_en, mode_clr, mode_en2, mode_clr2;
  logic [1:0] cur_mode, cur_mode2;
  logic [7:0] led_out, led_out2;

  int total = 0;
  int bad   = 0;

  led_mode_sequencer #(.TICK_DIV(1), .STEPS(4)) dut (
    .clk(clk), .reset(reset), .en(en), .auto(auto),
    .mode_sel(mode_sel), .sel_load(sel_load),
    .pat0(pat0), .pat1(pat1), .pat2(pat2), .pat3(pat3),
    .mode_en(mode_en), .mode_clr(mode_clr), .cur_mode(cur_mode), .OUT(led_out)
  );

  led_mode_sequencer #(.TICK_DIV(3), .STEPS(2)) dut2 (
    .clk(clk), .reset(reset2), .en(en2), .auto(auto),
    .mode_sel(mode_sel), .sel_load(sel_load),
    .pat0(pat0), .pat1(pat1), .pat2(pat2), .pat3(pat3),
    .mode_en(mode_en2), .mode_clr(mode_clr2), .cur_mode(cur_mode2), .OUT(led_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] out;
    logic [3:0] men;
    logic [3:0] clr;
    logic [1:0] cur;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic e, input logic [7:0] o, input logic [3:0] m,
                         input logic [3:0] c, input logic [1:0] cm);
    vec_t v;
    v.en = e; v.out = o; v.men = m; v.clr = c; v.cur = cm;
    vecs.push_back(v);
  endtask

  initial begin
    int dev;
    logic [7:0] exp_o;
    logic [3:0] exp_c;

    reset = 1'b0; reset2 = 1'b0;
    en = 1'b0; en2 = 1'b0; auto = 1'b1;
    mode_sel = 2'd0; sel_load = 1'b0;
    pat0 = 8'h11; pat1 = 8'h22; pat2 = 8'h33; pat3 = 8'h44;

    // Full auto rotation through all four modes back to mode 0
    add_vec(1'b1, 8'h00, 4'b0000, 4'b0001, 2'd0);
    for (int k = 0; k < 4; k++) begin
      int nk;
      logic [7:0] prev_o, cur_o;
      nk     = (k + 1) % 4;
      prev_o = (k == 0) ? 8'h00 : 8'(8'h11 * k);
      cur_o  = 8'(8'h11 * (k + 1));
      add_vec(1'b1, prev_o, 4'(1 << k), 4'b0000, 2'(k));
      for (int s = 0; s < 3; s++) add_vec(1'b1, cur_o, 4'(1 << k), 4'b0000, 2'(k));
      add_vec(1'b1, cur_o, 4'b0000, 4'b0000, 2'(k));
      add_vec(1'b1, cur_o, 4'b0000, 4'(1 << nk), 2'(nk));
    end

    repeat (2) cyc();
    check("reset_out", 32'(led_out), 32'h00);
    check("reset_men", 32'(mode_en), 32'h0);
    check("reset_clr", 32'(mode_clr), 32'h0);
    check("reset_cur", 32'(cur_mode), 32'h0);
    reset = 1'b1;
    cyc();
    check("idle_hold_clr", 32'(mode_clr), 32'h0);

    foreach (vecs[i]) begin
      en = vecs[i].en;
      cyc();
      check($sformatf("vec%0d_out", i), 32'(led_out), 32'(vecs[i].out));
      check($sformatf("vec%0d_men", i), 32'(mode_en), 32'(vecs[i].men));
      check($sformatf("vec%0d_clr", i), 32'(mode_clr), 32'(vecs[i].clr));
      check($sformatf("vec%0d_cur", i), 32'(cur_mode), 32'(vecs[i].cur));
    end

    // en low for 5 cycles with step_cnt=2 in mode 0
    cyc(); check("run0_men", 32'(mode_en), 32'h1); check("run0_out", 32'(led_out), 32'h44);
    cyc(); check("run0_t0", 32'(led_out), 32'h11);
    cyc(); check("run0_t1", 32'(led_out), 32'h11);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("frz%0d_men", i), 32'(mode_en), 32'h0);
      check($sformatf("frz%0d_out", i), 32'(led_out), 32'h11);
      check($sformatf("frz%0d_clr", i), 32'(mode_clr), 32'h0);
    end
    en = 1'b1;
    cyc(); check("unfrz_tick1_men", 32'(mode_en), 32'h1);
    cyc(); check("unfrz_tick2_sw", 32'(mode_en), 32'h0);
    cyc();
    check("unfrz_start_clr", 32'(mode_clr), 32'b0010);
    check("unfrz_start_cur", 32'(cur_mode), 32'h1);

    // Manual select of mode 2 with auto off, then hold
    auto = 1'b0;
    cyc(); check("m1_run_men", 32'(mode_en), 32'b0010);
    sel_load = 1'b1; mode_sel = 2'd2;
    cyc(); check("sel_switch_men", 32'(mode_en), 32'h0);
    sel_load = 1'b0;
    cyc();
    check("sel_start_cur", 32'(cur_mode), 32'h2);
    check("sel_start_clr", 32'(mode_clr), 32'b0100);
    cyc(); check("sel_run_men", 32'(mode_en), 32'b0100);
    dev = 0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      if (mode_en != 4'b0100 || mode_clr != 4'b0000 || cur_mode != 2'd2) dev++;
    end
    check("hold_no_switch", 32'(dev), 32'h0);
    check("hold_out", 32'(led_out), 32'h33);

    // sel_load(3) on the final auto tick of mode 0 wins over rotation to 1
    auto = 1'b1; sel_load = 1'b1; mode_sel = 2'd0;
    cyc(); check("rst0_switch_men", 32'(mode_en), 32'h0);
    sel_load = 1'b0;
    cyc();
    check("rst0_start_cur", 32'(cur_mode), 32'h0);
    check("rst0_start_clr", 32'(mode_clr), 32'b0001);
    cyc(); check("rst0_run_men", 32'(mode_en), 32'b0001);
    repeat (3) cyc();
    sel_load = 1'b1; mode_sel = 2'd3;
    cyc(); check("race_switch_out", 32'(led_out), 32'h11);
    sel_load = 1'b0;
    cyc();
    check("race_cur", 32'(cur_mode), 32'h3);
    check("race_clr", 32'(mode_clr), 32'b1000);

    // Asynchronous reset mid-RUN, between clock edges
    cyc(); check("m3_run_men", 32'(mode_en), 32'b1000);
    cyc(); check("m3_out", 32'(led_out), 32'h44);
    #3 reset = 1'b0;
    #1;
    check("areset_out", 32'(led_out), 32'h00);
    check("areset_men", 32'(mode_en), 32'h0);
    check("areset_cur", 32'(cur_mode), 32'h0);
    check("areset_clr", 32'(mode_clr), 32'h0);
    en = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    dev = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (mode_clr != 4'b0000 || mode_en != 4'b0000) dev++;
    end
    check("post_reset_idle", 32'(dev), 32'h0);
    en = 1'b1;
    cyc();
    check("post_reset_start_clr", 32'(mode_clr), 32'b0001);

    // Divided ticks: TICK_DIV=3, STEPS=2 gives an 8-cycle mode period
    auto = 1'b1; sel_load = 1'b0;
    reset2 = 1'b1; en2 = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      cyc();
      exp_o = (k < 4) ? 8'h00 : ((k < 12) ? 8'h11 : 8'h22);
      exp_c = (k == 0) ? 4'b0001 : ((k == 8) ? 4'b0010 : ((k == 16) ? 4'b0100 : 4'b0000));
      check($sformatf("div_e%0d_out", k), 32'(led_out2), 32'(exp_o));
      check($sformatf("div_e%0d_clr", k), 32'(mode_clr2), 32'(exp_c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
